// File: rtl/alu_divider.sv
// alu_divider: restoring unsigned divider that borrows an external combinational ALU for its SUB steps
package alu_defs;
    localparam logic [3:0] AND = 4'b0000;
    localparam logic [3:0] OR  = 4'b0001;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    typedef struct packed {
        logic carryOut;
        logic zero;
        logic negative;
        logic overflow;
    } t_flag;
endpackage

module alu_divider #(
    parameter int N = 32
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iStart,
    input  logic [N-1:0]          iDividend,
    input  logic [N-1:0]          iDivisor,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [N-1:0]          oQuotient,
    output logic [N-1:0]          oRemainder,
    output logic                  oDivByZero,
    output logic [N-1:0]          oAluX,
    output logic [N-1:0]          oAluY,
    output logic [3:0]            oAluOp,
    input  logic [N-1:0]          iAluF,
    input  alu_defs::t_flag       iAluFlag
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} t_state;
    t_state         state_q, state_d;
    logic [N-1:0]   q_q, q_d, d_q, d_d, p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quotient_q, quotient_d, remainder_q, remainder_d;
    logic           div_by_zero_q, div_by_zero_d;
    logic [N-1:0]   shifted, p_step, q_step;
    logic           ov, take, last_step;
    logic           unused_flags;
    // ov means the shifted remainder has N+1 bits, so it always exceeds D and the wrapped difference is exact
    assign shifted      = {p_q[N-2:0], q_q[N-1]};
    assign ov           = p_q[N-1];
    assign take         = ov | ~iAluFlag.carryOut;
    assign p_step       = take ? iAluF : shifted;
    assign q_step       = {q_q[N-2:0], take};
    assign last_step    = cnt_q == CW'(1);
    assign oAluOp       = alu_defs::SUB;
    assign oQuotient    = quotient_q;
    assign oRemainder   = remainder_q;
    assign oDivByZero   = div_by_zero_q;
    assign unused_flags = ^{iAluFlag.zero, iAluFlag.negative, iAluFlag.overflow};
    // State register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end
    // Next state: zero divisor skips RUN, RUN lasts exactly N steps
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = iStart ? ((iDivisor == '0) ? DONE : RUN) : IDLE;
            RUN:     state_d = last_step ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end
    // FSM outputs; the ALU operands are parked at zero outside RUN
    always_comb begin
        oBusy = state_q != IDLE;
        oDone = state_q == DONE;
        oAluX = (state_q == RUN) ? shifted : '0;
        oAluY = (state_q == RUN) ? d_q : '0;
    end
    // Datapath next values; results are captured on the edge that enters DONE so they are valid with oDone
    always_comb begin
        q_d           = q_q;
        d_d           = d_q;
        p_d           = p_q;
        cnt_d         = cnt_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        if (state_q == IDLE && iStart) begin
            if (iDivisor != '0) begin
                q_d   = iDividend;
                d_d   = iDivisor;
                p_d   = '0;
                cnt_d = CW'(N);
            end else begin
                quotient_d    = '1;
                remainder_d   = iDividend;
                div_by_zero_d = 1'b1;
            end
        end else if (state_q == RUN) begin
            q_d   = q_step;
            p_d   = p_step;
            cnt_d = cnt_q - 1'b1;
            if (last_step) begin
                quotient_d    = q_step;
                remainder_d   = p_step;
                div_by_zero_d = 1'b0;
            end
        end
    end
    // Datapath registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            q_q           <= '0;
            d_q           <= '0;
            p_q           <= '0;
            cnt_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            q_q           <= q_d;
            d_q           <= d_d;
            p_q           <= p_d;
            cnt_q         <= cnt_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end
endmodule
